regfile_write_queue: RTL and testbench

//  Writer side of the register-file write port. Merges writebacks from the pipeline WB stage
//  and an auxiliary multicycle source (mult/div, late loads) into an in-order queue.

---
 rtl/regfile_write_queue.sv | 107 ++++++++++
 tb/tb_regfile_write_queue.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_queue.sv
// In-order register-file write queue merging WB and auxiliary writebacks.
// Drains one entry per cycle and exposes pending-destination and bypass lookup.
module regfile_write_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  input  logic [ADDR_W-1:0]         wb_reg,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic                      aux_valid,
  input  logic [ADDR_W-1:0]         aux_reg,
  input  logic [DATA_W-1:0]         aux_data,
  output logic                      aux_ready,
  output logic                      rf_write,
  output logic [ADDR_W-1:0]         rf_reg,
  output logic [DATA_W-1:0]         rf_data,
  input  logic [ADDR_W-1:0]         lookup_reg,
  output logic                      lookup_hit,
  output logic [DATA_W-1:0]         lookup_data,
  output logic [31:0]               pending_mask,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] aux_slot;
  logic [CNT_W-1:0] count_nxt;
  logic             wb_push;
  logic             aux_push;
  logic             pop;
  entry_t           head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // Push/pop decisions; register 0 writes are accepted but never stored
  always_comb begin
    aux_ready  = (count < CNT_W'(DEPTH));
    wb_push    = wb_valid && (wb_reg != '0);
    aux_push   = aux_valid && aux_ready && (aux_reg != '0);
    pop        = (count != '0);
    aux_slot   = wb_push ? ptr_inc(wr_ptr) : wr_ptr;
    wr_ptr_nxt = aux_push ? ptr_inc(aux_slot) : aux_slot;
    count_nxt  = count - CNT_W'(pop) + CNT_W'(wb_push) + CNT_W'(aux_push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
      if (wb_push)  mem_q[wr_ptr]   <= '{rd: wb_reg,  data: wb_data};
      if (aux_push) mem_q[aux_slot] <= '{rd: aux_reg, data: aux_data};
    end
  end

  always_comb begin
    head     = mem_q[rd_ptr];
    rf_write = (count != '0);
    rf_reg   = rf_write ? head.rd   : '0;
    rf_data  = rf_write ? head.data : '0;
  end

  // Scan oldest to youngest so the youngest match overrides older ones
  always_comb begin
    int unsigned slot;
    entry_t      ent;
    slot         = 0;
    ent          = '0;
    pending_mask = '0;
    lookup_hit   = 1'b0;
    lookup_data  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = 32'(rd_ptr) + i;
      if (slot >= DEPTH) slot = slot - DEPTH;
      ent = mem_q[PTR_W'(slot)];
      if (i < 32'(count)) begin
        pending_mask[ent.rd] = 1'b1;
        if ((lookup_reg != '0) && (ent.rd == lookup_reg)) begin
          lookup_hit  = 1'b1;
          lookup_data = ent.data;
        end
      end
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_regfile_write_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        aux_valid;
  logic [4:0]  aux_reg;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic        rf_write;
  logic [4:0]  rf_reg;
  logic [31:0] rf_data;
  logic [4:0]  lookup_reg;
  logic        lookup_hit;
  logic [31:0] lookup_data;
  logic [31:0] pending_mask;
  logic [2:0]  count;

  regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .aux_valid(aux_valid), .aux_reg(aux_reg), .aux_data(aux_data), .aux_ready(aux_ready),
    .rf_write(rf_write), .rf_reg(rf_reg), .rf_data(rf_data),
    .lookup_reg(lookup_reg), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
    .pending_mask(pending_mask), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        wv;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic [4:0]  lr;
    logic        e_w;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic        e_hit;
    logic [31:0] e_ldata;
    logic [31:0] e_mask;
  } vec_t;

  ent_t        q[$];
  logic [31:0] regs [32];
  int          total = 0;
  int          bad   = 0;
  vec_t        tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Compare all outputs against the model's view of the current queue
  task automatic check_model(input string tag);
    logic        e_hit;
    logic [31:0] e_ld;
    logic [31:0] e_mask;
    e_hit  = 1'b0;
    e_ld   = '0;
    e_mask = '0;
    foreach (q[i]) begin
      e_mask[q[i].r] = 1'b1;
      if (lookup_reg != 0 && q[i].r == lookup_reg) begin
        e_hit = 1'b1;
        e_ld  = q[i].d;
      end
    end
    chk({tag, " rf_write"},  32'(rf_write),  32'(q.size() != 0));
    chk({tag, " rf_reg"},    32'(rf_reg),    (q.size() != 0) ? 32'(q[0].r) : 32'd0);
    chk({tag, " rf_data"},   rf_data,        (q.size() != 0) ? q[0].d : 32'd0);
    chk({tag, " count"},     32'(count),     32'(q.size()));
    chk({tag, " aux_ready"}, 32'(aux_ready), 32'(q.size() < DEPTH));
    chk({tag, " hit"},       32'(lookup_hit), 32'(e_hit));
    chk({tag, " ldata"},     lookup_data,    e_ld);
    chk({tag, " mask"},      pending_mask,   e_mask);
  endtask

  // Called at a negedge: drive, check current state, advance model across the posedge
  task automatic step(input string tag, input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                      input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic [4:0] lr);
    logic rdy;
    ent_t e;
    wb_valid = wv; wb_reg = wr; wb_data = wd;
    aux_valid = av; aux_reg = ar; aux_data = ad;
    lookup_reg = lr;
    #1;
    check_model(tag);
    if (rf_write) regs[rf_reg] = rf_data;
    @(posedge clk);
    rdy = (q.size() < DEPTH);
    if (q.size() != 0) void'(q.pop_front());
    if (wv && wr != 0) begin e.r = wr; e.d = wd; q.push_back(e); end
    if (av && rdy && ar != 0) begin e.r = ar; e.d = ad; q.push_back(e); end
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic [4:0] lr);
    step(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, lr);
  endtask

  initial begin
    foreach (regs[i]) regs[i] = '0;
    //        wv wr     wd        av ar     ad      lr     w  reg    data      cnt  rdy hit ldata  mask
    tbl[0]  = '{1, 5'd8,  32'h1234, 0, 5'd0,  32'h0, 5'd0,  1, 5'd8,  32'h1234, 3'd1, 1, 0, 32'h0, 32'h100};
    tbl[1]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0, 5'd8,  0, 5'd0,  32'h0,    3'd0, 1, 0, 32'h0, 32'h0};
    tbl[2]  = '{1, 5'd9,  32'hA,    1, 5'd10, 32'hB, 5'd10, 1, 5'd9,  32'hA,    3'd2, 1, 1, 32'hB, 32'h600};
    tbl[3]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0, 5'd9,  1, 5'd10, 32'hB,    3'd1, 1, 0, 32'h0, 32'h400};
    tbl[4]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0, 5'd0,  0, 5'd0,  32'h0,    3'd0, 1, 0, 32'h0, 32'h0};
    tbl[5]  = '{1, 5'd0,  32'hFFFF, 1, 5'd0,  32'h1, 5'd0,  0, 5'd0,  32'h0,    3'd0, 1, 0, 32'h0, 32'h0};
    tbl[6]  = '{1, 5'd5,  32'h1,    1, 5'd5,  32'h2, 5'd5,  1, 5'd5,  32'h1,    3'd2, 1, 1, 32'h2, 32'h20};
    tbl[7]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0, 5'd5,  1, 5'd5,  32'h2,    3'd1, 1, 1, 32'h2, 32'h20};
    tbl[8]  = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0, 5'd5,  0, 5'd0,  32'h0,    3'd0, 1, 0, 32'h0, 32'h0};
    tbl[9]  = '{1, 5'd5,  32'h1,    0, 5'd0,  32'h0, 5'd5,  1, 5'd5,  32'h1,    3'd1, 1, 1, 32'h1, 32'h20};
    tbl[10] = '{1, 5'd5,  32'h2,    0, 5'd0,  32'h0, 5'd5,  1, 5'd5,  32'h2,    3'd1, 1, 1, 32'h2, 32'h20};
    tbl[11] = '{0, 5'd0,  32'h0,    0, 5'd0,  32'h0, 5'd5,  0, 5'd0,  32'h0,    3'd0, 1, 0, 32'h0, 32'h0};

    rst = 1'b1;
    wb_valid = 0; wb_reg = 0; wb_data = 0;
    aux_valid = 0; aux_reg = 0; aux_data = 0; lookup_reg = 0;
    repeat (2) @(negedge clk);
    #1;
    check_model("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed table: expectations observed after the edge that samples the row
    for (int i = 0; i < 12; i++) begin
      step($sformatf("row%0d", i), tbl[i].wv, tbl[i].wr, tbl[i].wd, tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].lr);
      #1;
      chk($sformatf("tbl%0d rf_write", i),  32'(rf_write),    32'(tbl[i].e_w));
      chk($sformatf("tbl%0d rf_reg", i),    32'(rf_reg),      32'(tbl[i].e_reg));
      chk($sformatf("tbl%0d rf_data", i),   rf_data,          tbl[i].e_data);
      chk($sformatf("tbl%0d count", i),     32'(count),       32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d aux_ready", i), 32'(aux_ready),   32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d hit", i),       32'(lookup_hit),  32'(tbl[i].e_hit));
      chk($sformatf("tbl%0d ldata", i),     lookup_data,      tbl[i].e_ldata);
      chk($sformatf("tbl%0d mask", i),      pending_mask,     tbl[i].e_mask);
      #1;
    end
    idle("post_tbl", 5'd0);
    chk("regs8",  regs[8],  32'h1234);
    chk("regs9",  regs[9],  32'hA);
    chk("regs10", regs[10], 32'hB);
    chk("regs5",  regs[5],  32'h2);

    // Saturation: wb and aux every cycle; count climbs 2,3,4 then holds at 4
    for (int i = 0; i < 14; i++) begin
      step("sat", 1'b1, 5'(1 + i % 7), 32'(100 + i), 1'b1, 5'(8 + i % 7), 32'(200 + i), 5'(1 + i % 7));
      #1;
      chk($sformatf("sat%0d count", i), 32'(count), (i == 0) ? 32'd2 : (i == 1) ? 32'd3 : 32'd4);
      chk($sformatf("sat%0d aux_ready", i), 32'(aux_ready), (i < 2) ? 32'd1 : 32'd0);
      #1;
    end
    for (int i = 0; i < 5; i++) idle("sat_drain", 5'd9);
    chk("sat empty", 32'(count), 32'd0);

    // Asynchronous reset with three entries queued
    step("pre_rst0", 1'b1, 5'd1, 32'd11, 1'b1, 5'd2, 32'd22, 5'd0);
    step("pre_rst1", 1'b1, 5'd4, 32'd44, 1'b1, 5'd6, 32'd66, 5'd4);
    #1;
    chk("pre_rst count", 32'(count), 32'd3);
    wb_valid = 0; aux_valid = 0;
    #1;
    rst = 1'b1;
    #1;
    chk("async rf_write", 32'(rf_write), 32'd0);
    chk("async count", 32'(count), 32'd0);
    chk("async mask", pending_mask, 32'd0);
    chk("async hit", 32'(lookup_hit), 32'd0);
    chk("async aux_ready", 32'(aux_ready), 32'd1);
    #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    step("post_rst", 1'b1, 5'd3, 32'd7, 1'b0, 5'd0, 32'd0, 5'd3);
    #1;
    chk("post_rst rf_reg", 32'(rf_reg), 32'd3);
    chk("post_rst rf_data", rf_data, 32'd7);
    #1;
    idle("post_rst_drain", 5'd3);
    chk("regs3", regs[3], 32'd7);

    // Random traffic with frequent register collisions
    for (int i = 0; i < 400; i++) begin
      step("rnd", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 6; i++) idle("rnd_drain", 5'($urandom_range(0, 7)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
